// File: rtl/alu_pkg.sv
// Shared types for the two-port ALU sharing controller: ALU op encodings,
// flag layout and controller state.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011
  } alu_ctrl_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } share_state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Bus bundle between the two requesters, the shared ALU and the result consumer.
// ALU_ARB_LOCK_EN adds the per-port lock inputs.
interface alu_share_ctrl_if #(parameter int N = 4) ();

  logic         r0_valid, r0_ready, r0_setf;
  logic [N-1:0] r0_a, r0_b;
  logic [2:0]   r0_ctrl;
  logic         r1_valid, r1_ready, r1_setf;
  logic [N-1:0] r1_a, r1_b;
  logic [2:0]   r1_ctrl;
`ifdef ALU_ARB_LOCK_EN
  logic         r0_lock, r1_lock;
`endif
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_ctrl;
  logic [3:0]   alu_nzcv;
  logic         out_valid, out_ready, out_id;
  logic [N-1:0] out_result;
  logic [3:0]   out_nzcv, flags_q;

  // Controller side
  modport slave (
`ifdef ALU_ARB_LOCK_EN
    input  r0_lock, r1_lock,
`endif
    input  r0_valid, r0_a, r0_b, r0_ctrl, r0_setf,
    input  r1_valid, r1_a, r1_b, r1_ctrl, r1_setf,
    output r0_ready, r1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_nzcv,
    output out_valid, out_result, out_id, out_nzcv, flags_q,
    input  out_ready
  );

  // Requester / ALU / consumer side
  modport master (
`ifdef ALU_ARB_LOCK_EN
    output r0_lock, r1_lock,
`endif
    output r0_valid, r0_a, r0_b, r0_ctrl, r0_setf,
    output r1_valid, r1_a, r1_b, r1_ctrl, r1_setf,
    input  r0_ready, r1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_nzcv,
    input  out_valid, out_result, out_id, out_nzcv, flags_q,
    output out_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; an owner (from a locked carry chain) overrides
// the rotation and blocks the other port.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       owned,
  input  logic       owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (owned) begin
      grant[owner] = valid[owner];
    end else if (valid == 2'b11) begin
      grant[~last_grant] = 1'b1;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters with registered issue and
// result capture. Define ALU_ARB_LOCK_EN to enable owner locking for carry chains.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input logic         clk,
  input logic         rst_n,
  alu_share_ctrl_if.slave bus
);

  share_state_t state;
  nzcv_t        flags_r;
  logic         last_grant, setf_q, id_q;
  logic         can_accept, accept, winner;
  logic [1:0]   grant, ready;
  logic         owned, owner;
  logic [N-1:0] sel_a, sel_b;
  logic [2:0]   sel_ctrl;
  logic         sel_setf;

  // A new op can only enter when the result slot is free or being drained.
  assign can_accept = (state == IDLE) || ((state == DONE) && bus.out_ready);

  rr_arb2 u_arb (
    .valid      ({bus.r1_valid, bus.r0_valid}),
    .last_grant (last_grant),
    .owned      (owned),
    .owner      (owner),
    .grant      (grant)
  );

  assign ready        = can_accept ? grant : 2'b00;
  assign bus.r0_ready = ready[0];
  assign bus.r1_ready = ready[1];
  assign accept       = |ready;
  assign winner       = ready[1];
  assign sel_a        = winner ? bus.r1_a    : bus.r0_a;
  assign sel_b        = winner ? bus.r1_b    : bus.r0_b;
  assign sel_ctrl     = winner ? bus.r1_ctrl : bus.r0_ctrl;
  assign sel_setf     = winner ? bus.r1_setf : bus.r0_setf;
  assign bus.flags_q  = flags_r;

`ifdef ALU_ARB_LOCK_EN
  logic sel_lock;
  assign sel_lock = winner ? bus.r1_lock : bus.r0_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owned <= 1'b0;
      owner <= 1'b0;
    end else if (accept) begin
      owned <= sel_lock;
      if (sel_lock) owner <= winner;
    end
  end
`else
  assign owned = 1'b0;
  assign owner = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_ctrl   <= 3'b000;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_id     <= 1'b0;
      bus.out_nzcv   <= 4'h0;
      flags_r        <= '0;
      last_grant     <= 1'b1;
      setf_q         <= 1'b0;
      id_q           <= 1'b0;
    end else begin
      // Operands only move on accept, so the ALU inputs stay quiet during stalls.
      if (accept) begin
        bus.alu_a    <= sel_a;
        bus.alu_b    <= sel_b;
        bus.alu_ctrl <= sel_ctrl;
        setf_q       <= sel_setf;
        id_q         <= winner;
        last_grant   <= winner;
      end
      case (state)
        IDLE: if (accept) state <= EXEC;
        EXEC: begin
          state          <= DONE;
          bus.out_valid  <= 1'b1;
          bus.out_result <= bus.alu_result;
          bus.out_nzcv   <= bus.alu_nzcv;
          bus.out_id     <= id_q;
          if (setf_q) flags_r <= bus.alu_nzcv;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU on the shared port.
// Define ALU_ARB_LOCK_EN to also exercise owner locking.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic         id;
    logic [N-1:0] result;
    logic [3:0]   nzcv;
    logic         setf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_flags = 4'h0;

  always #5 clk = ~clk;

  alu_share_ctrl_if #(.N(N)) bus ();

  alu_share_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ARM-style flags: C is carry-out on ADD and not-borrow on SUB.
  function automatic logic [N+3:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [2:0] ctrl);
    logic [N:0]   s;
    logic [N-1:0] r;
    logic         c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (ctrl)
      ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[N-1:0]; c = s[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        r = s[N-1:0]; c = s[N];
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      AND:     r = a & b;
      OR:      r = a | b;
      default: r = '0;
    endcase
    return {r, r[N-1], (r == '0), c, v};
  endfunction

  always_comb {bus.alu_result, bus.alu_nzcv} = alu_model(bus.alu_a, bus.alu_b, bus.alu_ctrl);

  // Monitor: samples just before each rising edge, when the handshakes are settled.
  initial begin : monitor
    exp_t e;
    exp_t n;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        sb.delete();
        exp_flags = 4'h0;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_unexpected: out_valid with nothing pending, out_result=%h", bus.out_result);
          end else begin
            e = sb.pop_front();
            if (bus.out_result !== e.result || bus.out_nzcv !== e.nzcv || bus.out_id !== e.id) begin
              errors++;
              $display("[TB] FAIL sb_result: got id=%0d res=%h nzcv=%b, expected id=%0d res=%h nzcv=%b",
                       bus.out_id, bus.out_result, bus.out_nzcv, e.id, e.result, e.nzcv);
            end
            if (e.setf) exp_flags = e.nzcv;
            checks++;
            if (bus.flags_q !== exp_flags) begin
              errors++;
              $display("[TB] FAIL sb_flags: flags_q=%b expected %b", bus.flags_q, exp_flags);
            end
          end
        end
        checks++;
        if (bus.r0_ready && bus.r1_ready) begin
          errors++;
          $display("[TB] FAIL ready_onehot: r0_ready=1 r1_ready=1 expected at most one");
        end
        if (bus.r0_valid && bus.r0_ready) begin
          n.id = 1'b0; n.setf = bus.r0_setf;
          {n.result, n.nzcv} = alu_model(bus.r0_a, bus.r0_b, bus.r0_ctrl);
          sb.push_back(n);
          grant_log.push_back(0);
        end
        if (bus.r1_valid && bus.r1_ready) begin
          n.id = 1'b1; n.setf = bus.r1_setf;
          {n.result, n.nzcv} = alu_model(bus.r1_a, bus.r1_b, bus.r1_ctrl);
          sb.push_back(n);
          grant_log.push_back(1);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus_idle();
    bus.r0_valid = 1'b0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_ctrl = 3'b000; bus.r0_setf = 1'b0;
    bus.r1_valid = 1'b0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_ctrl = 3'b000; bus.r1_setf = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    bus.r0_lock = 1'b0; bus.r1_lock = 1'b0;
`endif
    bus.out_ready = 1'b0;
  endtask

  // Presents one op on port k from a falling edge and holds it until accepted.
  task automatic send(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [2:0] ctrl, input logic setf);
    int   cnt;
    logic got;
    if (k == 0) begin
      bus.r0_a = a; bus.r0_b = b; bus.r0_ctrl = ctrl; bus.r0_setf = setf; bus.r0_valid = 1'b1;
    end else begin
      bus.r1_a = a; bus.r1_b = b; bus.r1_ctrl = ctrl; bus.r1_setf = setf; bus.r1_valid = 1'b1;
    end
    cnt = 0; got = 1'b0;
    while (!got && cnt < 50) begin
      #4;
      got = (k == 0) ? bus.r0_ready : bus.r1_ready;
      @(negedge clk);
      cnt++;
    end
    if (k == 0) bus.r0_valid = 1'b0; else bus.r1_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL send_timeout: port %0d ready=0 after %0d cycles, expected 1", k, cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus_idle();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== '0) begin
      errors++; $display("[TB] FAIL reset_alu: a=%h b=%h ctrl=%h expected 0", bus.alu_a, bus.alu_b, bus.alu_ctrl);
    end
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_id, bus.out_nzcv} !== '0) begin
      errors++; $display("[TB] FAIL reset_out: valid=%b res=%h id=%b nzcv=%b expected 0",
                         bus.out_valid, bus.out_result, bus.out_id, bus.out_nzcv);
    end
    checks++;
    if (bus.flags_q !== 4'h0 || bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags_ready: flags_q=%b r0_ready=%b r1_ready=%b expected 0",
                         bus.flags_q, bus.r0_ready, bus.r1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    send(0, 4'b0111, 4'b0001, ADD, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL add_exec_valid: out_valid=%b expected 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 4'b1000 || bus.out_nzcv !== 4'b1001 || bus.out_id !== 1'b0) begin
      errors++; $display("[TB] FAIL add_result: valid=%b res=%b nzcv=%b id=%b expected 1 1000 1001 0",
                         bus.out_valid, bus.out_result, bus.out_nzcv, bus.out_id);
    end
    checks++;
    if (bus.flags_q !== 4'b1001) begin
      errors++; $display("[TB] FAIL add_flags: flags_q=%b expected 1001", bus.flags_q);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL add_drain: out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_sub();
    send(1, 4'b0101, 4'b0101, SUB, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 4'b0000 || bus.out_nzcv !== 4'b0110 || bus.out_id !== 1'b1) begin
      errors++; $display("[TB] FAIL sub_result: valid=%b res=%b nzcv=%b id=%b expected 1 0000 0110 1",
                         bus.out_valid, bus.out_result, bus.out_nzcv, bus.out_id);
    end
    checks++;
    if (bus.flags_q !== 4'b1001) begin
      errors++; $display("[TB] FAIL sub_flags_hold: flags_q=%b expected 1001", bus.flags_q);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic g0, g1;
    grant_log.delete();
    bus.out_ready = 1'b1;
    bus.r0_a = 4'($urandom); bus.r0_b = 4'($urandom); bus.r0_ctrl = 3'($urandom_range(0, 3));
    bus.r0_setf = 1'($urandom); bus.r0_valid = 1'b1;
    bus.r1_a = 4'($urandom); bus.r1_b = 4'($urandom); bus.r1_ctrl = 3'($urandom_range(0, 3));
    bus.r1_setf = 1'($urandom); bus.r1_valid = 1'b1;
    repeat (12) begin
      #4;
      g0 = bus.r0_ready; g1 = bus.r1_ready;
      @(negedge clk);
      if (g0) begin
        bus.r0_a = 4'($urandom); bus.r0_b = 4'($urandom);
        bus.r0_ctrl = 3'($urandom_range(0, 3)); bus.r0_setf = 1'($urandom);
      end
      if (g1) begin
        bus.r1_a = 4'($urandom); bus.r1_b = 4'($urandom);
        bus.r1_ctrl = 3'($urandom_range(0, 3)); bus.r1_setf = 1'($urandom);
      end
    end
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (grant_log.size() != 6) begin
      errors++; $display("[TB] FAIL b2b_count: %0d grants expected 6", grant_log.size());
    end
    for (int i = 0; i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[i] != i % 2) begin
        errors++; $display("[TB] FAIL b2b_order: grant %0d went to port %0d expected %0d", i, grant_log[i], i % 2);
      end
    end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    send(0, 4'b1100, 4'b1010, AND, 1'b1);
    bus.r1_a = 4'b0011; bus.r1_b = 4'b0100; bus.r1_ctrl = OR; bus.r1_setf = 1'b0; bus.r1_valid = 1'b1;
    @(negedge clk);
    repeat (5) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 4'b1000 || bus.out_nzcv !== 4'b1000 ||
          bus.out_id !== 1'b0 || bus.flags_q !== 4'b1000) begin
        errors++; $display("[TB] FAIL stall_out: valid=%b res=%b nzcv=%b id=%b flags=%b expected 1 1000 1000 0 1000",
                           bus.out_valid, bus.out_result, bus.out_nzcv, bus.out_id, bus.flags_q);
      end
      checks++;
      if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0 || bus.alu_a !== 4'b1100 ||
          bus.alu_b !== 4'b1010 || bus.alu_ctrl !== 3'b010) begin
        errors++; $display("[TB] FAIL stall_hold: r0_ready=%b r1_ready=%b alu_a=%b alu_b=%b ctrl=%b expected 0 0 1100 1010 010",
                           bus.r0_ready, bus.r1_ready, bus.alu_a, bus.alu_b, bus.alu_ctrl);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #4;
    checks++;
    if (bus.r1_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_release_ready: r1_ready=%b expected 1", bus.r1_ready);
    end
    @(negedge clk);
    bus.r1_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.alu_a !== 4'b0011 || bus.alu_ctrl !== 3'b011) begin
      errors++; $display("[TB] FAIL stall_reissue: valid=%b alu_a=%b ctrl=%b expected 0 0011 011",
                         bus.out_valid, bus.alu_a, bus.alu_ctrl);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 4'b0111 || bus.out_nzcv !== 4'b0000 ||
        bus.out_id !== 1'b1 || bus.flags_q !== 4'b1000) begin
      errors++; $display("[TB] FAIL stall_resume: valid=%b res=%b nzcv=%b id=%b flags=%b expected 1 0111 0000 1 1000",
                         bus.out_valid, bus.out_result, bus.out_nzcv, bus.out_id, bus.flags_q);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    send(0, 4'b0111, 4'b0001, ADD, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.flags_q !== 4'h0 || bus.alu_a !== 4'h0) begin
      errors++; $display("[TB] FAIL midreset_clear: valid=%b flags=%b alu_a=%b expected 0 0000 0000",
                         bus.out_valid, bus.flags_q, bus.alu_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.flags_q !== 4'h0) begin
        errors++; $display("[TB] FAIL midreset_quiet: valid=%b flags=%b expected 0 0000", bus.out_valid, bus.flags_q);
      end
    end
  endtask

`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock();
    logic g0, g1;
    int   j, cyc;
    grant_log.delete();
    bus.out_ready = 1'b1;
    j = 0; cyc = 0;
    bus.r1_a = 4'b0001; bus.r1_b = 4'b0010; bus.r1_ctrl = ADD; bus.r1_setf = 1'b0; bus.r1_valid = 1'b1;
    bus.r0_a = 4'b1111; bus.r0_b = 4'b0001; bus.r0_ctrl = ADD; bus.r0_setf = 1'b1;
    bus.r0_lock = 1'b1; bus.r0_valid = 1'b1;
    while (grant_log.size() < 4 && cyc < 40) begin
      #4;
      g0 = bus.r0_ready; g1 = bus.r1_ready;
      @(negedge clk);
      cyc++;
      if (g0) begin
        j++;
        if (j < 3) begin
          bus.r0_a = 4'($urandom); bus.r0_b = 4'($urandom); bus.r0_lock = (j < 2);
        end else begin
          bus.r0_valid = 1'b0; bus.r0_lock = 1'b0;
        end
      end
      if (g1) bus.r1_valid = 1'b0;
    end
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (grant_log.size() != 4) begin
      errors++; $display("[TB] FAIL lock_count: %0d grants expected 4", grant_log.size());
    end
    for (int i = 0; i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[i] != ((i < 3) ? 0 : 1)) begin
        errors++; $display("[TB] FAIL lock_order: grant %0d went to port %0d expected %0d",
                           i, grant_log[i], (i < 3) ? 0 : 1);
      end
    end
  endtask
`endif

  initial begin : main
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef ALU_ARB_LOCK_EN
    test_lock();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL sb_leftover: %0d results never produced, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
